// File: rtl/sevenseg_scan_driver_pkg.sv
// Shared 7-segment encodings and polarity helpers for every display driver in the stopwatch/timer family.
// Segment vectors are always {g,f,e,d,c,b,a}, so bit 0 is segment a.
package sevenseg_scan_driver_pkg;

    localparam int SEG_W     = 7;
    localparam int NUM_DIGITS = 4;

    localparam int SEG_A_BIT = 0;
    localparam int SEG_B_BIT = 1;
    localparam int SEG_C_BIT = 2;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 4;
    localparam int SEG_F_BIT = 5;
    localparam int SEG_G_BIT = 6;

    typedef logic [SEG_W-1:0]      seg_t;
    typedef logic [NUM_DIGITS-1:0] an_t;
    typedef logic [3:0]            bcd_t;

    // Active-high decode constants
    localparam seg_t SEG_0    = 7'b0111111;
    localparam seg_t SEG_1    = 7'b0000110;
    localparam seg_t SEG_2    = 7'b1011011;
    localparam seg_t SEG_3    = 7'b1001111;
    localparam seg_t SEG_4    = 7'b1100110;
    localparam seg_t SEG_5    = 7'b1101101;
    localparam seg_t SEG_6    = 7'b1111101;
    localparam seg_t SEG_7    = 7'b0000111;
    localparam seg_t SEG_8    = 7'b1111111;
    localparam seg_t SEG_9    = 7'b1101111;
    localparam seg_t SEG_DASH = 7'b1000000;
    localparam seg_t SEG_OFF  = 7'b0000000;
    localparam an_t  AN_OFF   = 4'b0000;

    // One bundle of display pins in logical (active-high) sense
    typedef struct packed {
        an_t  an;
        seg_t seg;
        logic dp;
    } disp_t;

    localparam disp_t DISP_OFF = '{an: AN_OFF, seg: SEG_OFF, dp: 1'b0};

    // Map logical levels onto the physical pin polarity
    function automatic disp_t disp_to_pins(input disp_t logical, input bit active_low);
        disp_t pins;
        pins = active_low ? ~logical : logical;
        return pins;
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_bcd_to_sevenseg.sv
// Combinational BCD to 7-segment decoder, active-high {g..a}.
// Non-BCD codes 10..15 show a dash so a corrupted digit is visible rather than silently wrong.
module bcd_to_sevenseg
    import sevenseg_scan_driver_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame digit snapshot, leading-zero blanking,
// decimal points, anti-ghost guard time and whole-display blink. All outputs are registered.
module sevenseg_scan_driver
    import sevenseg_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 2,
    parameter int BLINK_FRAMES = 125,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] dig3_i,
    input  logic [3:0] dig2_i,
    input  logic [3:0] dig1_i,
    input  logic [3:0] dig0_i,
    input  logic [3:0] dp_mask_i,
    input  logic       blank_lz_i,
    input  logic       blink_i,
    output logic [3:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic       frame_done_o
);

    localparam int PC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(REFRESH_DIV - 1);
    localparam logic [PC_W-1:0] PC_GUARD = PC_W'(GUARD_CYCLES);
    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(BLINK_FRAMES - 1);
    localparam disp_t PINS_OFF = disp_to_pins(DISP_OFF, ACTIVE_LOW);

    logic [PC_W-1:0]       pc_q, pc_d;
    logic [1:0]            idx_q, idx_d;
    logic [3:0][3:0]       snap_q, snap_d;
    logic [3:0]            snap_dp_q, snap_dp_d;
    logic [FC_W-1:0]       fc_q, fc_d;
    logic                  bph_q, bph_d;
    disp_t                 pins_q, pins_d;
    logic                  frame_done_q, frame_done_d;

    logic [3:0][3:0]       dig_in;
    logic [3:0]            blank;
    logic                  slot_end;
    logic                  frame_end;
    logic                  show;
    seg_t                  seg_dec;
    disp_t                 logical;

    assign dig_in    = {dig3_i, dig2_i, dig1_i, dig0_i};
    assign slot_end  = (pc_q == PC_LAST);
    assign frame_end = slot_end && (idx_q == 2'd3);

    // Leading-zero blanking ripples right from the leftmost digit; digit 0 always shows.
    assign blank[3] = blank_lz_i && (snap_q[3] == 4'd0);
    assign blank[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 3; gi++) begin : g_blank
            assign blank[gi] = blank[gi+1] && (snap_q[gi] == 4'd0);
        end
    endgenerate

    bcd_to_sevenseg u_decode (
        .bcd_i (snap_q[idx_q]),
        .seg_o (seg_dec)
    );

    // Scan counters, per-frame snapshot and blink phase
    always_comb begin
        pc_d         = pc_q + PC_W'(1);
        idx_d        = idx_q;
        snap_d       = snap_q;
        snap_dp_d    = snap_dp_q;
        fc_d         = fc_q;
        bph_d        = bph_q;
        frame_done_d = 1'b0;
        if (slot_end) begin
            pc_d  = '0;
            idx_d = idx_q + 2'd1;
        end
        if (frame_end) begin
            snap_d       = dig_in;
            snap_dp_d    = dp_mask_i;
            frame_done_d = 1'b1;
            if (fc_q == FC_LAST) begin
                fc_d  = '0;
                bph_d = ~bph_q;
            end else begin
                fc_d = fc_q + FC_W'(1);
            end
        end
    end

    // Display pins for the current slot; segments are also dark whenever the anodes are
    always_comb begin
        show    = (pc_q >= PC_GUARD) && !blank[idx_q] && !(blink_i && bph_q);
        logical = DISP_OFF;
        if (show) begin
            logical.an  = an_t'(4'b0001 << idx_q);
            logical.seg = seg_dec;
            logical.dp  = snap_dp_q[idx_q];
        end
        pins_d = disp_to_pins(logical, ACTIVE_LOW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= '0;
            idx_q        <= '0;
            snap_q       <= '0;
            snap_dp_q    <= '0;
            fc_q         <= '0;
            bph_q        <= 1'b0;
            pins_q       <= PINS_OFF;
            frame_done_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            snap_dp_q    <= snap_dp_d;
            fc_q         <= fc_d;
            bph_q        <= bph_d;
            pins_q       <= pins_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an_o         = pins_q.an;
    assign seg_o        = pins_q.seg;
    assign dp_o         = pins_q.dp;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with REFRESH_DIV=4, GUARD_CYCLES=1, BLINK_FRAMES=2, active-low.
// k counts rising edges since reset release; slot of edge k is ((k-1)/4)%4, prescaler (k-1)%4, one-cycle output lag.
module tb_sevenseg_scan_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] dig3, dig2, dig1, dig0, dp_mask;
    logic       blank_lz, blink;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, frame_done;

    int checks = 0;
    int errors = 0;
    int k = 0;

    always #5 clk = ~clk;

    sevenseg_scan_driver #(
        .REFRESH_DIV  (4),
        .GUARD_CYCLES (1),
        .BLINK_FRAMES (2),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dig3_i       (dig3),
        .dig2_i       (dig2),
        .dig1_i       (dig1),
        .dig0_i       (dig0),
        .dp_mask_i    (dp_mask),
        .blank_lz_i   (blank_lz),
        .blink_i      (blink),
        .an_o         (an),
        .seg_o        (seg),
        .dp_o         (dp),
        .frame_done_o (frame_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic adv_to(input int target);
        while (k < target) tick();
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    task automatic chk_an(input string tag, input logic [3:0] exp_an);
        chk({tag, ".an"}, {3'b000, an}, {3'b000, exp_an});
    endtask

    task automatic chk_disp(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
        chk({tag, ".an"}, {3'b000, an}, {3'b000, exp_an});
        chk({tag, ".seg"}, seg, exp_seg);
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        dig3 = d3; dig2 = d2; dig1 = d1; dig0 = d0;
    endtask

    initial begin
        reset = 1'b1; blank_lz = 1'b0; blink = 1'b0; dp_mask = 4'b0100;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);

        // Reset held three cycles: everything dark
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_disp("rst", 4'b1111, 7'b1111111);
            chk("rst.dp", {6'd0, dp}, 7'd1);
            chk("rst.fd", {6'd0, frame_done}, 7'd0);
        end
        reset = 1'b0; k = 0;

        // Frame 1 shows the zeroed snapshot
        tick();      chk_an("f1.guard", 4'b1111);
        tick();      chk_disp("f1.s0", 4'b1110, 7'b1000000);
        adv_to(15);  chk("f1.fd_lo", {6'd0, frame_done}, 7'd0);
        adv_to(16);  chk("f1.fd_hi", {6'd0, frame_done}, 7'd1);

        // Frame 2 shows 1 2 3 4 with dp on digit 2
        adv_to(17);  chk_an("f2.guard0", 4'b1111);
                     chk("f2.fd_off", {6'd0, frame_done}, 7'd0);
        adv_to(18);  chk_disp("f2.s0", 4'b1110, 7'b0011001);
                     chk("f2.s0.dp", {6'd0, dp}, 7'd1);
        adv_to(21);  chk_an("f2.guard1", 4'b1111);
        adv_to(22);  chk_disp("f2.s1", 4'b1101, 7'b0110000);
        adv_to(25);  chk_an("f2.guard2", 4'b1111);
        adv_to(26);  chk_disp("f2.s2", 4'b1011, 7'b0100100);
                     chk("f2.s2.dp", {6'd0, dp}, 7'd0);
        adv_to(30);  chk_disp("f2.s3", 4'b0111, 7'b1111001);
                     chk("f2.s3.dp", {6'd0, dp}, 7'd1);
        adv_to(31);  chk("f2.fd_lo", {6'd0, frame_done}, 7'd0);
        adv_to(32);  chk("f2.fd_hi", {6'd0, frame_done}, 7'd1);

        // Leading-zero blanking: 0 0 0 7 -> "   7"
        set_digits(4'd0, 4'd0, 4'd0, 4'd7); blank_lz = 1'b1; dp_mask = 4'b0001;
        adv_to(48);  chk("f3.fd_hi", {6'd0, frame_done}, 7'd1);
        adv_to(50);  chk_disp("lz.s0", 4'b1110, 7'b1111000);
                     chk("lz.s0.dp", {6'd0, dp}, 7'd0);
        adv_to(54);  chk_an("lz.s1", 4'b1111);
        adv_to(58);  chk_an("lz.s2", 4'b1111);
        adv_to(62);  chk_an("lz.s3", 4'b1111);

        // 0 5 0 7 -> only digit 3 blank
        set_digits(4'd0, 4'd5, 4'd0, 4'd7);
        adv_to(66);  chk_disp("lz2.s0", 4'b1110, 7'b1111000);
        adv_to(70);  chk_disp("lz2.s1", 4'b1101, 7'b1000000);
        adv_to(74);  chk_disp("lz2.s2", 4'b1011, 7'b0010010);
        adv_to(78);  chk_an("lz2.s3", 4'b1111);

        // 1 9 5 9 snapshotted, then changed to 2 0 0 0 mid-frame
        set_digits(4'd1, 4'd9, 4'd5, 4'd9);
        adv_to(82);  chk_disp("snap.s0", 4'b1110, 7'b0010000);
        adv_to(86);  chk_disp("snap.s1", 4'b1101, 7'b0010010);
        set_digits(4'd2, 4'd0, 4'd0, 4'd0);
        adv_to(90);  chk_disp("snap.s2", 4'b1011, 7'b0010000);
        adv_to(94);  chk_disp("snap.s3", 4'b0111, 7'b1111001);
        adv_to(96);  chk("snap.fd", {6'd0, frame_done}, 7'd1);
        adv_to(98);  chk_disp("new.s0", 4'b1110, 7'b1000000);
        adv_to(102); chk_disp("new.s1", 4'b1101, 7'b1000000);
        adv_to(106); chk_disp("new.s2", 4'b1011, 7'b1000000);
        adv_to(110); chk_disp("new.s3", 4'b0111, 7'b0100100);

        // Non-BCD digit shows a dash
        dig0 = 4'hC;
        adv_to(114); chk_disp("dash.s0", 4'b1110, 7'b0111111);

        // Blink: phase already off in this frame, then 2 on / 2 off
        blink = 1'b1;
        adv_to(118); chk_an("blink.f8", 4'b1111);
        adv_to(130); chk_disp("blink.f9", 4'b1110, 7'b0111111);
        adv_to(146); chk_disp("blink.f10", 4'b1110, 7'b0111111);
        adv_to(162); chk_an("blink.f11a", 4'b1111);
        adv_to(166); chk_an("blink.f11b", 4'b1111);
        adv_to(178); chk_an("blink.f12", 4'b1111);

        // Reset mid-slot with blink phase and frame counter non-zero
        reset = 1'b1;
        tick();
        chk_disp("rst2", 4'b1111, 7'b1111111);
        chk("rst2.dp", {6'd0, dp}, 7'd1);
        chk("rst2.fd", {6'd0, frame_done}, 7'd0);
        reset = 1'b0; k = 0;

        tick();      chk_an("r.guard", 4'b1111);
        tick();      chk_disp("r.s0", 4'b1110, 7'b1000000);
        adv_to(6);   chk_an("r.s1", 4'b1111);
        adv_to(15);  chk("r.fd_lo", {6'd0, frame_done}, 7'd0);
        adv_to(16);  chk("r.fd_hi", {6'd0, frame_done}, 7'd1);
        adv_to(18);  chk_disp("r.f2", 4'b1110, 7'b0111111);
        adv_to(34);  chk_an("r.f3", 4'b1111);
        adv_to(50);  chk_an("r.f4", 4'b1111);
        adv_to(66);  chk_disp("r.f5", 4'b1110, 7'b0111111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
